// File: rtl/io16_pkg.sv
// +------------------------------------------------------------------+
// | io16_pkg : shared constants and types for the io16 I/O expander   |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package io16_pkg;

  localparam int CNT_W       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int ARM_CYCLES  = 2;

  // Bit positions within the synchronized input vector (s1 is bit 0)
  localparam int N_IN        = 18;
  localparam int IDX_S9      = 8;
  localparam int IDX_S10     = 9;
  localparam int IDX_S11     = 10;
  localparam int IDX_S12     = 11;
  localparam int IDX_S13     = 12;
  localparam int IDX_S14     = 13;
  localparam int IDX_S15     = 14;
  localparam int IDX_S16     = 15;
  localparam int IDX_CLK_1M  = 16;
  localparam int IDX_CLK_1HZ = 17;

  typedef enum logic [2:0] {
    CLR  = 3'd0,
    HOLD = 3'd1,
    INC  = 3'd2,
    DEC  = 3'd3,
    AUTO = 3'd4,
    NONE = 3'd5
  } cnt_op_e;

  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] v,
                                                input logic             down);
    return down ? v - CNT_W'(1) : v + CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/io16_sync_edge.sv
// +------------------------------------------------------------------+
// | io16_sync_edge : vector 2-FF synchronizer with armed rise detect  |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module io16_sync_edge
  import io16_pkg::*;
#(
  parameter int WIDTH = N_IN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] stage_d [SYNC_STAGES];
  logic [WIDTH-1:0] dly_q;
  logic [WIDTH-1:0] dly_d;

  // While unarmed the delay stage is primed with the value the sync stage
  // is about to take, so a level present through reset never looks like an edge.
  always_comb begin
    stage_d[0] = async_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    dly_d = arm ? stage_q[SYNC_STAGES-1] : stage_q[SYNC_STAGES-2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
      dly_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
      dly_q <= dly_d;
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];
  assign rise_o = arm ? (sync_o & ~dly_q) : '0;

endmodule

`default_nettype wire

// File: rtl/io16_verilog.sv
// +------------------------------------------------------------------+
// | io16_verilog : 16-switch / 16-LED expander, counter and mirrors   |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module io16_verilog
  import io16_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clk_1MHz,
  input  logic clk_1Hz,
  input  logic s1,
  input  logic s2,
  input  logic s3,
  input  logic s4,
  input  logic s5,
  input  logic s6,
  input  logic s7,
  input  logic s8,
  input  logic s9,
  input  logic s10,
  input  logic s11,
  input  logic s12,
  input  logic s13,
  input  logic s14,
  input  logic s15,
  input  logic s16,
  output logic led1,
  output logic led2,
  output logic led3,
  output logic led4,
  output logic led5,
  output logic led6,
  output logic led7,
  output logic led8,
  output logic led9,
  output logic led10,
  output logic led11,
  output logic led12,
  output logic led13,
  output logic led14,
  output logic led15,
  output logic led16
);

  localparam int ARM_W = $clog2(ARM_CYCLES + 1);

  logic [N_IN-1:0]  async_in;
  logic [N_IN-1:0]  sync_v;
  logic [N_IN-1:0]  rise_v;
  logic [ARM_W-1:0] arm_cnt_q;
  logic [ARM_W-1:0] arm_cnt_d;
  logic             arm;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [7:0]       led_lo_q;
  logic [7:0]       led_lo_d;
  cnt_op_e          cnt_op;
  logic             unused_bits;

  assign async_in = {clk_1Hz, clk_1MHz, s16, s15, s14, s13, s12, s11, s10, s9,
                     s8, s7, s6, s5, s4, s3, s2, s1};

  io16_sync_edge #(
    .WIDTH (N_IN)
  ) u_sync_edge (
    .clk     (clk),
    .reset   (reset),
    .arm     (arm),
    .async_i (async_in),
    .sync_o  (sync_v),
    .rise_o  (rise_v)
  );

  assign arm = (arm_cnt_q == ARM_W'(ARM_CYCLES));

  always_comb begin
    arm_cnt_d = arm ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
  end

  always_comb begin
    cnt_op = NONE;
    if (rise_v[IDX_S11]) begin
      cnt_op = CLR;
    end else if (sync_v[IDX_S13]) begin
      cnt_op = HOLD;
    end else if (rise_v[IDX_S9] && rise_v[IDX_S10]) begin
      cnt_op = NONE;
    end else if (rise_v[IDX_S9]) begin
      cnt_op = INC;
    end else if (rise_v[IDX_S10]) begin
      cnt_op = DEC;
    end else if (sync_v[IDX_S12] && rise_v[IDX_CLK_1HZ]) begin
      cnt_op = AUTO;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case (cnt_op)
      CLR:     cnt_d = '0;
      INC:     cnt_d = cnt_step(cnt_q, 1'b0);
      DEC:     cnt_d = cnt_step(cnt_q, 1'b1);
      AUTO:    cnt_d = cnt_step(cnt_q, sync_v[IDX_S14]);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    led_lo_d = rise_v[IDX_CLK_1M] ? sync_v[7:0] : led_lo_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arm_cnt_q <= '0;
      cnt_q     <= '0;
      led_lo_q  <= '0;
    end else begin
      arm_cnt_q <= arm_cnt_d;
      cnt_q     <= cnt_d;
      led_lo_q  <= led_lo_d;
    end
  end

  // Edge/level bits this block has no use for
  assign unused_bits = ^{rise_v[7:0], rise_v[IDX_S16:IDX_S12],
                         sync_v[IDX_S11:IDX_S9], sync_v[IDX_CLK_1M]};

  assign {led8, led7, led6, led5, led4, led3, led2, led1} = led_lo_q;
  assign {led12, led11, led10, led9} = cnt_q;
  assign led13 = (cnt_q == '0);
  assign led14 = sync_v[IDX_CLK_1HZ];
  assign led15 = sync_v[IDX_S15];
  assign led16 = sync_v[IDX_S16];

endmodule

`default_nettype wire

// File: tb/tb_io16_verilog.sv
// +------------------------------------------------------------------+
// | tb_io16_verilog : directed bench with cycle-level reference model |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_io16_verilog;

  logic        clk;
  logic        reset;
  logic        clk_1mhz;
  logic        clk_1hz;
  logic [15:0] sw;
  logic [15:0] led;
  logic        mhz_en;
  int          mhz_div;

  int n_cmp;
  int n_bad;

  io16_verilog dut (
    .clk      (clk),
    .reset    (reset),
    .clk_1MHz (clk_1mhz),
    .clk_1Hz  (clk_1hz),
    .s1  (sw[0]),  .s2  (sw[1]),  .s3  (sw[2]),  .s4  (sw[3]),
    .s5  (sw[4]),  .s6  (sw[5]),  .s7  (sw[6]),  .s8  (sw[7]),
    .s9  (sw[8]),  .s10 (sw[9]),  .s11 (sw[10]), .s12 (sw[11]),
    .s13 (sw[12]), .s14 (sw[13]), .s15 (sw[14]), .s16 (sw[15]),
    .led1  (led[0]),  .led2  (led[1]),  .led3  (led[2]),  .led4  (led[3]),
    .led5  (led[4]),  .led6  (led[5]),  .led7  (led[6]),  .led8  (led[7]),
    .led9  (led[8]),  .led10 (led[9]),  .led11 (led[10]), .led12 (led[11]),
    .led13 (led[12]), .led14 (led[13]), .led15 (led[14]), .led16 (led[15])
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // 1 MHz board clock: toggles every 25 system cycles while enabled
  always @(negedge clk) begin
    if (!mhz_en) begin
      clk_1mhz = 1'b0;
      mhz_div  = 0;
    end else begin
      mhz_div = mhz_div + 1;
      if (mhz_div == 25) begin
        mhz_div  = 0;
        clk_1mhz = ~clk_1mhz;
      end
    end
  end

  // Reference model: sampled-input history, counter as an integer mod 16
  logic [17:0] h0, h1, h2;
  int          since_rst;
  int          m_cnt;
  logic [7:0]  m_lo;
  logic        model_valid = 1'b0;

  always @(posedge clk) begin
    logic [17:0] rs;
    if (reset) begin
      h0 = '0; h1 = '0; h2 = '0;
      since_rst   = 0;
      m_cnt       = 0;
      m_lo        = '0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      rs = (since_rst >= 3) ? (h1 & ~h2) : 18'd0;
      if (rs[10])                m_cnt = 0;
      else if (h1[12])           m_cnt = m_cnt;
      else if (rs[8] && rs[9])   m_cnt = m_cnt;
      else if (rs[8])            m_cnt = (m_cnt + 1) % 16;
      else if (rs[9])            m_cnt = (m_cnt + 15) % 16;
      else if (h1[11] && rs[17]) m_cnt = h1[13] ? (m_cnt + 15) % 16 : (m_cnt + 1) % 16;
      if (rs[16]) m_lo = h1[7:0];
      h2 = h1;
      h1 = h0;
      h0 = {clk_1hz, clk_1mhz, sw};
      if (since_rst < 1000) since_rst = since_rst + 1;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      check("cycle_leds", led,
            {h1[15], h1[14], h1[17], (m_cnt == 0), 4'(m_cnt), m_lo});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int idx);
    sw[idx] = 1'b1; cycles(5);
    sw[idx] = 1'b0; cycles(5);
  endtask

  task automatic pulse_1hz();
    clk_1hz = 1'b1; cycles(5);
    check("led14_high", {15'd0, led[13]}, 16'h0001);
    cycles(5);
    clk_1hz = 1'b0; cycles(10);
  endtask

  // led[12:8] = {led13, cnt}
  function automatic logic [15:0] cnt_field();
    return {11'd0, led[12:8]};
  endfunction

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; sw = '0; clk_1hz = 1'b0; mhz_en = 1'b0;
    cycles(3);
    reset = 1'b0;
    cycles(4);
    check("reset_leds", led, 16'h1000);

    repeat (5) pulse(8);
    check("cnt_5", cnt_field(), 16'h0005);
    repeat (2) pulse(9);
    check("cnt_3", cnt_field(), 16'h0003);
    pulse(10);
    check("clr_0", cnt_field(), 16'h0010);
    pulse(9);
    check("wrap_down_15", cnt_field(), 16'h000F);
    pulse(8);
    check("wrap_up_0", cnt_field(), 16'h0010);

    pulse(8);
    sw[12] = 1'b1; cycles(3);
    repeat (3) pulse(8);
    check("hold_1", cnt_field(), 16'h0001);
    pulse(10);
    check("clr_over_hold", cnt_field(), 16'h0010);
    sw[12] = 1'b0; cycles(3);

    sw[11] = 1'b1; sw[13] = 1'b0; cycles(3);
    repeat (3) pulse_1hz();
    check("auto_up_3", cnt_field(), 16'h0003);
    sw[13] = 1'b1; cycles(3);
    pulse_1hz();
    check("auto_down_2", cnt_field(), 16'h0002);
    sw[8] = 1'b1; clk_1hz = 1'b1; cycles(10);
    sw[8] = 1'b0; clk_1hz = 1'b0; cycles(10);
    check("manual_beats_tick", cnt_field(), 16'h0003);
    sw[11] = 1'b0; sw[13] = 1'b0; cycles(3);

    sw[7:0] = 8'hA5; sw[14] = 1'b1; mhz_en = 1'b1;
    cycles(60);
    check("mirror_a5", {8'd0, led[7:0]}, 16'h00A5);
    check("led15", {15'd0, led[14]}, 16'h0001);
    sw[7:0] = 8'h3C;
    cycles(60);
    check("mirror_3c", {8'd0, led[7:0]}, 16'h003C);
    mhz_en = 1'b0; sw[14] = 1'b0;

    sw[8] = 1'b1; reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(10);
    check("held_through_reset", cnt_field(), 16'h0010);
    sw[8] = 1'b0; cycles(5);
    pulse(8);
    check("after_reset_inc", cnt_field(), 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
